// File: rtl/data_memory_responder.sv
// rtl/data_memory_responder.sv - MEM-stage data-memory responder with fixed response latency
// Optional build macro: MISALIGN_TRAP_EN (misaligned H/W accesses complete with RespErr)
module data_memory_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        ReqValid,
  output logic        ReqReady,
  input  logic        ReqWr,
  input  logic [31:0] ReqAddr,
  input  logic [31:0] ReqData,
  input  logic [2:0]  ReqCtrl,
  output logic        RespValid,
  input  logic        RespReady,
  output logic [31:0] RespData,
  output logic        RespErr
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [3:0]     r_cnt;
  logic [3:0]     w_cnt_nxt;

  logic           r_wr;
  logic [AW+1:0]  r_addr;
  logic [31:0]    r_data;
  logic [2:0]     r_ctrl;

  logic           r_resp_valid;
  logic [31:0]    r_resp_data;
  logic           r_resp_err;

  logic [31:0]    r_mem [DEPTH_WORDS];

  logic           w_accept;
  logic           w_done;
  logic [AW-1:0]  w_idx;
  logic [31:0]    w_rd_word;
  logic [7:0]     w_byte;
  logic [15:0]    w_half;
  logic           w_err;
  logic [31:0]    w_load;
  logic [3:0]     w_be;
  logic [31:0]    w_wdata;
  logic           w_we;

  assign ReqReady  = (r_state == S_IDLE) && !Rst;
  assign RespValid = r_resp_valid;
  assign RespData  = r_resp_data;
  assign RespErr   = r_resp_err;

  assign w_accept  = ReqValid && ReqReady;
  assign w_done    = (r_state == S_WAIT) && (r_cnt == 4'd0);
  assign w_idx     = r_addr[AW+1:2];
  assign w_rd_word = r_mem[w_idx];
  assign w_half    = r_addr[1] ? w_rd_word[31:16] : w_rd_word[15:0];
  assign w_we      = w_done && r_wr && !w_err && !Rst;

  // Byte lane picked by the low address bits for byte loads
  always_comb begin
    w_byte = w_rd_word[7:0];
    case (r_addr[1:0])
      2'd0:    w_byte = w_rd_word[7:0];
      2'd1:    w_byte = w_rd_word[15:8];
      2'd2:    w_byte = w_rd_word[23:16];
      default: w_byte = w_rd_word[31:24];
    endcase
  end

  // Request rejection: unknown size codes, unsigned-store codes, optional alignment trap
  always_comb begin
    w_err = 1'b0;
    case (r_ctrl)
      3'b000, 3'b001, 3'b010: w_err = 1'b0;
      3'b100, 3'b101:         w_err = r_wr;
      default:                w_err = 1'b1;
    endcase
`ifdef MISALIGN_TRAP_EN
    if ((r_ctrl[1:0] == 2'b01) && r_addr[0])
      w_err = 1'b1;
    if ((r_ctrl == 3'b010) && (r_addr[1:0] != 2'b00))
      w_err = 1'b1;
`endif
  end

  // Load result with sign/zero extension; zero on rejected requests
  always_comb begin
    w_load = 32'd0;
    case (r_ctrl)
      3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load = {{16{w_half[15]}}, w_half};
      3'b010:  w_load = w_rd_word;
      3'b100:  w_load = {24'd0, w_byte};
      3'b101:  w_load = {16'd0, w_half};
      default: w_load = 32'd0;
    endcase
    if (w_err || r_wr)
      w_load = 32'd0;
  end

  // Store lane enables and replicated write data so any enabled lane sees the right bits
  always_comb begin
    w_be    = 4'b0000;
    w_wdata = r_data;
    case (r_ctrl[1:0])
      2'b00: begin
        w_be    = 4'b0001 << r_addr[1:0];
        w_wdata = {4{r_data[7:0]}};
      end
      2'b01: begin
        w_be    = r_addr[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{r_data[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = r_data;
      end
    endcase
  end

  // Next-state and latency counter
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (ReqValid) begin
          w_state_nxt = S_WAIT;
          w_cnt_nxt   = 4'(LATENCY - 1);
        end
      end
      S_WAIT: begin
        if (r_cnt != 4'd0)
          w_cnt_nxt = r_cnt - 4'd1;
        else
          w_state_nxt = S_RESP;
      end
      S_RESP: begin
        if (RespReady)
          w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Capture the request on the accept edge so later input changes are ignored
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_wr   <= 1'b0;
      r_addr <= '0;
      r_data <= 32'd0;
      r_ctrl <= 3'd0;
    end else if (w_accept) begin
      r_wr   <= ReqWr;
      r_addr <= ReqAddr[AW+1:0];
      r_data <= ReqData;
      r_ctrl <= ReqCtrl;
    end
  end

  // Response registers: loaded when the access completes, held until the handshake
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_resp_valid <= 1'b0;
      r_resp_data  <= 32'd0;
      r_resp_err   <= 1'b0;
    end else if (w_done) begin
      r_resp_valid <= 1'b1;
      r_resp_data  <= w_load;
      r_resp_err   <= w_err;
    end else if ((r_state == S_RESP) && RespReady) begin
      r_resp_valid <= 1'b0;
    end
  end

  // Storage array; contents survive reset, writes commit with the response
  always_ff @(posedge Clk) begin
    if (w_we) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i])
          r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_memory_responder.sv
// tb/tb_data_memory_responder.sv - self-checking bench for data_memory_responder
module tb_data_memory_responder;

  localparam int LAT    = 2;
  localparam int DEPTH  = 1024;
  localparam int NBYTES = DEPTH * 4;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        ReqValid = 1'b0;
  logic        ReqReady;
  logic        ReqWr = 1'b0;
  logic [31:0] ReqAddr = 32'd0;
  logic [31:0] ReqData = 32'd0;
  logic [2:0]  ReqCtrl = 3'd0;
  logic        RespValid;
  logic        RespReady = 1'b0;
  logic [31:0] RespData;
  logic        RespErr;

  int checks = 0;
  int errors = 0;

  logic [7:0] mbytes [NBYTES];

  data_memory_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .Clk(Clk), .Rst(Rst),
    .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqWr(ReqWr),
    .ReqAddr(ReqAddr), .ReqData(ReqData), .ReqCtrl(ReqCtrl),
    .RespValid(RespValid), .RespReady(RespReady),
    .RespData(RespData), .RespErr(RespErr)
  );

  always #5 Clk = ~Clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Byte-addressed little-endian reference memory
  task automatic model_access(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                              input logic [2:0] ctrl, output logic [31:0] ed, output logic ee);
    int size;
    int base;
    logic [31:0] v;
    ee = 1'b0;
    ed = 32'd0;
    size = 0;
    case (ctrl)
      3'd0, 3'd4: size = 1;
      3'd1, 3'd5: size = 2;
      3'd2:       size = 4;
      default:    ee = 1'b1;
    endcase
    if (ctrl[2] && wr) ee = 1'b1;
`ifdef MISALIGN_TRAP_EN
    if (!ee && size > 1 && (addr % size) != 0) ee = 1'b1;
`endif
    if (ee) return;
    base = int'(addr % NBYTES) / size * size;
    if (wr) begin
      for (int k = 0; k < size; k++) mbytes[base + k] = data[8*k +: 8];
    end else begin
      v = 32'd0;
      for (int k = 0; k < size; k++) v = v | (32'(mbytes[base + k]) << (8 * k));
      if (!ctrl[2] && size < 4 && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8 * size));
      ed = v;
    end
  endtask

  // Present a request at a negedge and wait for it to be taken; returns at the negedge after acceptance
  task automatic start_req(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                           input logic [2:0] ctrl, output logic ok);
    int n;
    ReqWr = wr; ReqAddr = addr; ReqData = data; ReqCtrl = ctrl; ReqValid = 1'b1;
    n = 0;
    while (!ReqReady && n < 50) begin
      @(negedge Clk);
      n++;
    end
    ok = ReqReady;
    if (ok) @(posedge Clk);
    @(negedge Clk);
    ReqValid = 1'b0;
    ReqAddr = $urandom;
    ReqData = $urandom;
  endtask

  // Count edges from the accept edge until RespValid is seen
  task automatic wait_resp(output int n);
    n = 0;
    while (!RespValid && n < 40) begin
      @(negedge Clk);
      n++;
    end
  endtask

  // Hold RespReady low for 'hold' cycles, report whether the response stayed put, then handshake
  task automatic finish_resp(input int hold, output logic st);
    logic [31:0] d0;
    logic e0;
    d0 = RespData; e0 = RespErr; st = 1'b1;
    repeat (hold) begin
      @(negedge Clk);
      if (RespValid !== 1'b1 || RespData !== d0 || RespErr !== e0) st = 1'b0;
    end
    RespReady = 1'b1;
    @(negedge Clk);
    RespReady = 1'b0;
  endtask

  task automatic run_txn(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                         input logic [2:0] ctrl, input int hold, output logic ok, output int lat,
                         output logic [31:0] d, output logic e, output logic st, output logic post);
    start_req(wr, addr, data, ctrl, ok);
    wait_resp(lat);
    d = RespData;
    e = RespErr;
    finish_resp(hold, st);
    post = (RespValid === 1'b0) && (ReqReady === 1'b1);
  endtask

  task automatic test_reset;
    Rst = 1'b1;
    @(negedge Clk);
    repeat (3) begin
      checks++;
      if (ReqReady !== 1'b0 || RespValid !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold: ReqReady=%b RespValid=%b, required 0/0", ReqReady, RespValid);
      end
      @(negedge Clk);
    end
    Rst = 1'b0;
    @(negedge Clk);
    checks++;
    if (ReqReady !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b, required 1", ReqReady); end
    checks++;
    if (RespValid !== 1'b0 || RespData !== 32'd0 || RespErr !== 1'b0) begin
      errors++;
      $display("FAIL reset_resp: valid=%b data=%h err=%b, required 0/0/0", RespValid, RespData, RespErr);
    end
  endtask

  task automatic test_preload;
    logic ok, e, st, post, ee;
    logic [31:0] d, ed, w;
    int lat;
    for (int i = 0; i < 32; i++) begin
      w = $urandom;
      model_access(1'b1, 32'(i * 4), w, 3'b010, ed, ee);
      run_txn(1'b1, 32'(i * 4), w, 3'b010, 0, ok, lat, d, e, st, post);
      checks++;
      if (e !== 1'b0 || d !== 32'd0) begin
        errors++;
        $display("FAIL preload_sw: word %0d err=%b data=%h, required 0/0", i, e, d);
      end
    end
  endtask

  task automatic test_store_load;
    logic ok, e, st, post, ee;
    logic [31:0] d, ed;
    int lat;
    model_access(1'b1, 32'h10, 32'hDEADBEEF, 3'b010, ed, ee);
    run_txn(1'b1, 32'h10, 32'hDEADBEEF, 3'b010, 0, ok, lat, d, e, st, post);
    checks++;
    if (lat !== LAT) begin errors++; $display("FAIL sw_latency: got %0d, required %0d", lat, LAT); end
    checks++;
    if (e !== 1'b0 || d !== 32'd0) begin errors++; $display("FAIL sw_resp: err=%b data=%h, required 0/0", e, d); end
    model_access(1'b0, 32'h10, 32'd0, 3'b010, ed, ee);
    run_txn(1'b0, 32'h10, 32'd0, 3'b010, 0, ok, lat, d, e, st, post);
    checks++;
    if (lat !== LAT) begin errors++; $display("FAIL lw_latency: got %0d, required %0d", lat, LAT); end
    checks++;
    if (d !== 32'hDEADBEEF || e !== 1'b0) begin
      errors++;
      $display("FAIL lw_data: got %h err=%b, required deadbeef err=0", d, e);
    end
    checks++;
    if (post !== 1'b1) begin errors++; $display("FAIL lw_release: got %b, required 1", post); end
  endtask

  task automatic test_byte_lanes;
    logic ok, e, st, post, ee;
    logic [31:0] d, ed;
    int lat;
    model_access(1'b1, 32'h11, 32'hA5A5A580, 3'b000, ed, ee);
    run_txn(1'b1, 32'h11, 32'hA5A5A580, 3'b000, 0, ok, lat, d, e, st, post);
    model_access(1'b0, 32'h11, 32'd0, 3'b000, ed, ee);
    run_txn(1'b0, 32'h11, 32'd0, 3'b000, 0, ok, lat, d, e, st, post);
    checks++;
    if (d !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_sign: got %h, required ffffff80", d); end
    model_access(1'b0, 32'h11, 32'd0, 3'b100, ed, ee);
    run_txn(1'b0, 32'h11, 32'd0, 3'b100, 0, ok, lat, d, e, st, post);
    checks++;
    if (d !== 32'h00000080) begin errors++; $display("FAIL lbu_zero: got %h, required 00000080", d); end
    model_access(1'b0, 32'h10, 32'd0, 3'b010, ed, ee);
    run_txn(1'b0, 32'h10, 32'd0, 3'b010, 0, ok, lat, d, e, st, post);
    checks++;
    if (d !== 32'hDEAD80EF) begin errors++; $display("FAIL sb_lane: got %h, required dead80ef", d); end
  endtask

  task automatic test_stall;
    logic ok, st, ee, hold_ok;
    logic [31:0] d0, ed;
    int n;
    model_access(1'b0, 32'h10, 32'd0, 3'b010, ed, ee);
    start_req(1'b0, 32'h10, 32'd0, 3'b010, ok);
    wait_resp(n);
    d0 = RespData;
    checks++;
    if (n !== LAT || d0 !== ed) begin
      errors++;
      $display("FAIL stall_first: lat=%0d data=%h, required %0d/%h", n, d0, LAT, ed);
    end
    ReqWr = 1'b0; ReqAddr = 32'h11; ReqData = 32'd0; ReqCtrl = 3'b100; ReqValid = 1'b1;
    hold_ok = 1'b1;
    repeat (5) begin
      @(negedge Clk);
      if (RespValid !== 1'b1 || RespData !== d0 || ReqReady !== 1'b0) hold_ok = 1'b0;
    end
    checks++;
    if (hold_ok !== 1'b1) begin errors++; $display("FAIL stall_hold: stable=%b, required 1", hold_ok); end
    RespReady = 1'b1;
    @(negedge Clk);
    RespReady = 1'b0;
    checks++;
    if (RespValid !== 1'b0 || ReqReady !== 1'b1) begin
      errors++;
      $display("FAIL stall_release: valid=%b ready=%b, required 0/1", RespValid, ReqReady);
    end
    @(negedge Clk);
    ReqValid = 1'b0;
    checks++;
    if (ReqReady !== 1'b0) begin errors++; $display("FAIL stall_accept: ready=%b, required 0", ReqReady); end
    model_access(1'b0, 32'h11, 32'd0, 3'b100, ed, ee);
    wait_resp(n);
    checks++;
    if (n !== LAT || RespData !== ed) begin
      errors++;
      $display("FAIL stall_second: lat=%0d data=%h, required %0d/%h", n, RespData, LAT, ed);
    end
    finish_resp(0, st);
  endtask

  task automatic test_misalign;
    logic ok, e, st, post, ee;
    logic [31:0] d, ed;
    int lat;
    model_access(1'b0, 32'h13, 32'd0, 3'b001, ed, ee);
    run_txn(1'b0, 32'h13, 32'd0, 3'b001, 0, ok, lat, d, e, st, post);
    checks++;
`ifdef MISALIGN_TRAP_EN
    if (e !== 1'b1 || d !== 32'd0) begin errors++; $display("FAIL lh_misalign: err=%b data=%h, required 1/0", e, d); end
`else
    if (e !== 1'b0 || d !== 32'hFFFFDEAD) begin errors++; $display("FAIL lh_misalign: err=%b data=%h, required 0/ffffdead", e, d); end
`endif
    model_access(1'b1, 32'h11, 32'h11223344, 3'b010, ed, ee);
    run_txn(1'b1, 32'h11, 32'h11223344, 3'b010, 0, ok, lat, d, e, st, post);
    checks++;
    if (e !== ee || lat !== LAT) begin errors++; $display("FAIL sw_misalign: err=%b lat=%0d, required %b/%0d", e, lat, ee, LAT); end
    model_access(1'b0, 32'h10, 32'd0, 3'b010, ed, ee);
    run_txn(1'b0, 32'h10, 32'd0, 3'b010, 0, ok, lat, d, e, st, post);
    checks++;
    if (d !== ed) begin errors++; $display("FAIL misalign_mem: got %h, required %h", d, ed); end
  endtask

  task automatic test_reset_abort;
    logic ok, e, st, post, ee, quiet;
    logic [31:0] d, ed;
    int lat;
    start_req(1'b1, 32'h20, 32'h12345678, 3'b010, ok);
    Rst = 1'b1;
    @(negedge Clk);
    checks++;
    if (RespValid !== 1'b0 || ReqReady !== 1'b0) begin
      errors++;
      $display("FAIL abort_rst: valid=%b ready=%b, required 0/0", RespValid, ReqReady);
    end
    @(negedge Clk);
    Rst = 1'b0;
    quiet = 1'b1;
    repeat (LAT + 3) begin
      @(negedge Clk);
      if (RespValid !== 1'b0) quiet = 1'b0;
    end
    checks++;
    if (quiet !== 1'b1) begin errors++; $display("FAIL abort_noresp: quiet=%b, required 1", quiet); end
    model_access(1'b0, 32'h20, 32'd0, 3'b010, ed, ee);
    run_txn(1'b0, 32'h20, 32'd0, 3'b010, 0, ok, lat, d, e, st, post);
    checks++;
    if (d !== ed || e !== 1'b0) begin errors++; $display("FAIL abort_mem: got %h, required %h", d, ed); end
  endtask

  task automatic test_illegal;
    logic ok, e, st, post, ee;
    logic [31:0] d, ed;
    logic [2:0] codes [4];
    logic [1:0] wrs [4];
    int lat;
    codes[0] = 3'b111; codes[1] = 3'b011; codes[2] = 3'b110; codes[3] = 3'b100;
    wrs[0] = 2'd0; wrs[1] = 2'd1; wrs[2] = 2'd0; wrs[3] = 2'd1;
    for (int i = 0; i < 4; i++) begin
      run_txn(wrs[i][0], 32'h24, 32'hCAFEF00D, codes[i], 1, ok, lat, d, e, st, post);
      checks++;
      if (e !== 1'b1 || d !== 32'd0 || lat !== LAT) begin
        errors++;
        $display("FAIL illegal_%0d: err=%b data=%h lat=%0d, required 1/0/%0d", i, e, d, lat, LAT);
      end
    end
    model_access(1'b0, 32'h24, 32'd0, 3'b010, ed, ee);
    run_txn(1'b0, 32'h24, 32'd0, 3'b010, 0, ok, lat, d, e, st, post);
    checks++;
    if (d !== ed) begin errors++; $display("FAIL illegal_nowrite: got %h, required %h", d, ed); end
  endtask

  task automatic test_random;
    logic ok, e, st, post, ee, wr;
    logic [31:0] d, ed, addr, data;
    logic [2:0] ctrl;
    int lat, hold;
    for (int i = 0; i < 200; i++) begin
      wr = 1'($urandom_range(0, 1));
      addr = $urandom & 32'hFFFF_F07F;
      data = $urandom;
      ctrl = 3'($urandom_range(0, 7));
      hold = $urandom_range(0, 2);
      model_access(wr, addr, data, ctrl, ed, ee);
      run_txn(wr, addr, data, ctrl, hold, ok, lat, d, e, st, post);
      checks++;
      if (ok !== 1'b1 || lat !== LAT) begin
        errors++;
        $display("FAIL rnd_latency[%0d]: ok=%b lat=%0d, required 1/%0d", i, ok, lat, LAT);
      end
      checks++;
      if (d !== ed || e !== ee) begin
        errors++;
        $display("FAIL rnd_data[%0d]: wr=%b addr=%h ctrl=%b got %h/%b, required %h/%b", i, wr, addr, ctrl, d, e, ed, ee);
      end
      checks++;
      if (st !== 1'b1 || post !== 1'b1) begin
        errors++;
        $display("FAIL rnd_handshake[%0d]: stable=%b release=%b, required 1/1", i, st, post);
      end
    end
  endtask

  initial begin
    test_reset;
    test_preload;
    test_store_load;
    test_byte_lanes;
    test_stall;
    test_misalign;
    test_reset_abort;
    test_illegal;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
